// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding, width/iteration constants and
// the special-case result constants.
package mul_div_unit_pkg;

  localparam int MDU_XLEN  = 32;
  localparam int MDU_ITERS = 32;

  localparam logic [MDU_XLEN-1:0] MDU_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [MDU_XLEN-1:0] MDU_INT_MIN  = 32'h8000_0000;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIN  = 2'b10
  } mdu_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;

  // rem_in < divisor always holds, so the difference fits in XLEN bits
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiply: 32-step shift-add on magnitudes, sign fixed in FIN.
// Divide: 32-step restoring division on magnitudes, signs fixed in FIN.
// Divide-by-zero and INT_MIN/-1 bypass CALC and finish in one cycle.
// Optional macro MDU_FAST_MUL_EN: multiplies skip CALC and use a native
// 33x33 signed multiply in FIN.
//
// state | meaning
// IDLE  | waiting for START
// CALC  | one multiply/divide iteration per clock
// FIN   | sign correction, RESULT load, DONE pulse
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITERS - 1);

  mdu_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              sign1_q, sign2_q;
  logic [XLEN-1:0]   mag1_q, mag2_q;
  logic [2*XLEN-1:0] acc_q;
  logic              spec_q;
  logic [XLEN-1:0]   spec_val_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              s1, s2, is_div, div_zero, div_ovf, special, skip_calc;
  logic [XLEN-1:0]   mag1, mag2, spec_val;

  logic [XLEN-1:0]   add_term;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN-1:0]   step_rem;
  logic              step_q;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, fin_val;

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

  // Request decode: magnitudes, sign flags and the CALC-bypass cases
  always_comb begin
    is_div   = FUNCT3[2];
    s1       = op1_signed(FUNCT3) & DATA1[XLEN-1];
    s2       = op2_signed(FUNCT3) & DATA2[XLEN-1];
    mag1     = s1 ? -DATA1 : DATA1;
    mag2     = s2 ? -DATA2 : DATA2;
    div_zero = is_div && (DATA2 == '0);
    div_ovf  = ((FUNCT3 == F3_DIV) || (FUNCT3 == F3_REM)) &&
               (DATA1 == MDU_INT_MIN) && (DATA2 == MDU_ALL_ONES);
    special  = div_zero || div_ovf;
    if (FUNCT3[1])
      spec_val = div_zero ? DATA1 : '0;
    else
      spec_val = div_zero ? MDU_ALL_ONES : MDU_INT_MIN;
`ifdef MDU_FAST_MUL_EN
    skip_calc = special || !is_div;
`else
    skip_calc = special;
`endif
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_q[2*XLEN-1:XLEN]),
    .dvd_bit (acc_q[XLEN-1]),
    .divisor (mag2_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_term = acc_q[0] ? mag1_q : '0;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, add_term};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_next = {step_rem, acc_q[XLEN-2:0], step_q};
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_full;
  logic                     unused_fast_hi;

  // Native signed product rebuilt from the latched magnitude and sign
  always_comb begin
    fast_a    = sign1_q ? -$signed({1'b0, mag1_q}) : $signed({1'b0, mag1_q});
    fast_b    = sign2_q ? -$signed({1'b0, mag2_q}) : $signed({1'b0, mag2_q});
    fast_full = fast_a * fast_b;
  end

  assign unused_fast_hi = ^fast_full[2*XLEN+1:2*XLEN];
`endif

  // Sign correction and result selection applied in FIN
  always_comb begin
`ifdef MDU_FAST_MUL_EN
    prod = fast_full[2*XLEN-1:0];
`else
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
`endif
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo     = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];
    if (f3_q[1])
      div_res = sign1_q ? -rem : rem;
    else
      div_res = (sign1_q ^ sign2_q) ? -quo : quo;
    fin_val = spec_q ? spec_val_q : (f3_q[2] ? div_res : mul_res);
  end

  // Next-state logic; FLUSH overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = skip_calc ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand latch, iteration datapath, counter and result/DONE registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q      <= '0;
      f3_q       <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      mag1_q     <= '0;
      mag2_q     <= '0;
      acc_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START && !FLUSH) begin
            f3_q       <= FUNCT3;
            sign1_q    <= s1;
            sign2_q    <= s2;
            mag1_q     <= mag1;
            mag2_q     <= mag2;
            cnt_q      <= '0;
            spec_q     <= special;
            spec_val_q <= spec_val;
            acc_q      <= is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
          end
        end
        ST_CALC: begin
          if (FLUSH) begin
            cnt_q <= '0;
          end else begin
            acc_q <= f3_q[2] ? div_next : mul_next;
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          end
        end
        ST_FIN: begin
          cnt_q <= '0;
          if (!FLUSH) begin
            result_q <= fin_val;
            done_q   <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: an arithmetic reference model with a
// latency countdown checked every cycle, plus directed vectors whose literal
// results pin both the model and the DUT.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .FLUSH  (FLUSH),
    .FUNCT3 (FUNCT3),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // RV32M arithmetic straight from the ISA rules
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    int         ia, ib;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return SPC_LAT;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPC_LAT;
    return DIV_LAT;
  endfunction

  // Model: edges remaining until DONE, pending result, visible result
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_result = '0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (FLUSH) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_done   = 1'b1;
            m_result = m_pend;
          end
        end
      end else if (START && !FLUSH) begin
        m_left = lat_of(FUNCT3, DATA1, DATA2);
        m_pend = ref_result(FUNCT3, DATA1, DATA2);
      end
    end
    #1;
    check("cyc_busy", 32'(BUSY), 32'(m_left > 0));
    check("cyc_done", 32'(DONE), 32'(m_done));
    check("cyc_result", RESULT, m_result);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Issue one request now; poke>0 re-asserts START at that busy cycle
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                       input int poke);
    int lat;
    lat = -1;
    check({name, "_model"}, ref_result(f3, a, b), exp_res);
    START  = 1'b1;
    FUNCT3 = f3;
    DATA1  = a;
    DATA2  = b;
    @(posedge CLK);
    #2;
    START = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #2;
      if (DONE) begin
        lat = i;
        break;
      end
      if (i == poke) begin
        START  = 1'b1;
        FUNCT3 = F3_DIV;
        DATA1  = 32'd5;
        DATA2  = 32'd0;
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, RESULT, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    @(posedge CLK);
    #2;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_result", RESULT, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    do_op("mul_7xm3",    F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
    do_op("mulhu_max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
    do_op("mulh_min",    F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
    do_op("mulhsu_m1x2", F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, 0);
    idle(2);
    do_op("div_m7_2",    F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, 0);
    do_op("rem_m7_2",    F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT, 0);
    do_op("divu_100_7",  F3_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, 0);
    do_op("remu_100_7",  F3_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT, 0);
    do_op("div_by0",     F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT, 0);
    do_op("rem_by0",     F3_REM,    32'd5,         32'd0,         32'd5,         SPC_LAT, 0);
    do_op("divu_by0",    F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT, 0);
    do_op("remu_by0",    F3_REMU,   32'd9,         32'd0,         32'd9,         SPC_LAT, 0);
    do_op("div_ovf",     F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, 0);
    do_op("rem_ovf",     F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT, 0);
    do_op("div_20_m6",   F3_DIV,    32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, DIV_LAT, 0);
    do_op("rem_20_m6",   F3_REM,    32'd20,        32'hFFFF_FFFA, 32'd2,         DIV_LAT, 0);
    do_op("mul_poke",    F3_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT, 5);

    // FLUSH sampled at the tenth edge of a DIV
    idle(2);
    START  = 1'b1;
    FUNCT3 = F3_DIV;
    DATA1  = 32'd1000;
    DATA2  = 32'd3;
    @(posedge CLK);
    #2;
    START = 1'b0;
    idle(9);
    FLUSH = 1'b1;
    @(posedge CLK);
    #2;
    FLUSH = 1'b0;
    check("flush_busy", 32'(BUSY), 32'd0);
    check("flush_result", RESULT, 32'h2345_6780);
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #2;
      if (DONE) seen = 1'b1;
    end
    check("flush_no_done", 32'(seen), 32'd0);

    // FLUSH wins over a simultaneous START in IDLE
    START  = 1'b1;
    FLUSH  = 1'b1;
    FUNCT3 = F3_DIVU;
    DATA1  = 32'd100;
    DATA2  = 32'd7;
    @(posedge CLK);
    #2;
    START = 1'b0;
    FLUSH = 1'b0;
    check("flush_vs_start_busy", 32'(BUSY), 32'd0);
    idle(2);

    // Asynchronous RESET in the middle of a MUL
    START  = 1'b1;
    FUNCT3 = F3_MUL;
    DATA1  = 32'd3;
    DATA2  = 32'd5;
    @(posedge CLK);
    #2;
    START = 1'b0;
    idle(5);
    RESET = 1'b1;
    #1;
    check("rstmid_busy", 32'(BUSY), 32'd0);
    check("rstmid_done", 32'(DONE), 32'd0);
    check("rstmid_result", RESULT, 32'd0);
    @(posedge CLK);
    #2;
    @(negedge CLK);
    RESET = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #2;
      if (DONE) seen = 1'b1;
    end
    check("rstmid_no_done", 32'(seen), 32'd0);

    do_op("divu_retrig", F3_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT, 0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
